seg_scan_decoder: RTL and testbench

Receiver for the multiplexed seven-segment display interface: samples the `sel`/`seg` scan bus produced by the display driver and rebuilds the six displayed digits as a 24-bit BCD word plus decimal points. It sits beside the display driver on the same clock. Uses: on-board self-check of the clock display, display readback, and a bench monitor for display-driver regressions.

---
 rtl/seg_scan_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan-bus receiver: debounces {sel,seg}, decodes each digit and
// rebuilds six-digit BCD frames with decimal points, error and stale flags.
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  sel,
  input  logic [7:0]  seg,
  output logic [23:0] data_out,
  output logic [5:0]  dp_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int unsigned TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT - 1);

  typedef enum logic {EMPTY, FILLING} state_t;

  state_t        state_q, state_d;
  logic [10:0]   in_q, in_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [5:0]    mask_q, mask_d;
  logic          acc_q, acc_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [5:0]    sdp_q, sdp_d;
  logic [23:0]   data_out_q, data_out_d;
  logic [5:0]    dp_out_q, dp_out_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          stale_q, stale_d;

  logic          change, capture, timeout;
  logic [3:0]    nib;
  logic          bad;
  logic [5:0]    mask_new;

  // Active-low g..a pattern to BCD; anything unrecognised flags the frame.
  always_comb begin
    bad = 1'b0;
    unique case (seg[6:0])
      7'h40:   nib = 4'd0;
      7'h79:   nib = 4'd1;
      7'h24:   nib = 4'd2;
      7'h30:   nib = 4'd3;
      7'h19:   nib = 4'd4;
      7'h12:   nib = 4'd5;
      7'h02:   nib = 4'd6;
      7'h78:   nib = 4'd7;
      7'h00:   nib = 4'd8;
      7'h10:   nib = 4'd9;
      default: begin
        nib = 4'hF;
        bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    in_d         = {sel, seg};
    change       = (in_d != in_q);
    cnt_d        = cnt_q;
    done_d       = done_q;
    tcnt_d       = tcnt_q;
    mask_d       = mask_q;
    acc_d        = acc_q;
    shadow_d     = shadow_q;
    sdp_d        = sdp_q;
    data_out_d   = data_out_q;
    dp_out_d     = dp_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    stale_d      = stale_q;
    state_d      = state_q;
    mask_new     = mask_q;

    if (change) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (cnt_q != SETTLE_C) begin
      cnt_d = cnt_q + 8'd1;
    end

    capture = !change && (cnt_q == SETTLE_M1) && !done_q && (sel <= 3'd5);
    // Capture takes priority over an expiring timeout on the same edge.
    timeout = !capture && (tcnt_q == TMO_M1);

    if (capture) begin
      done_d = 1'b1;
      tcnt_d = '0;
    end else if (tcnt_q != TMO_M1) begin
      tcnt_d = tcnt_q + TW'(1);
    end

    if (capture) begin
      for (int unsigned k = 0; k < 6; k++) begin
        if (sel == 3'(k)) begin
          shadow_d[4*k +: 4] = nib;
          sdp_d[k]           = ~seg[7];
        end
      end
      mask_new = mask_q | (6'd1 << sel);
      if (mask_new == 6'h3F) begin
        data_out_d   = shadow_d;
        dp_out_d     = sdp_d;
        frame_err_d  = acc_q | bad;
        data_valid_d = 1'b1;
        stale_d      = 1'b0;
        mask_d       = '0;
        acc_d        = 1'b0;
        state_d      = EMPTY;
      end else begin
        mask_d  = mask_new;
        acc_d   = acc_q | bad;
        if (state_q == EMPTY) state_d = FILLING;
      end
    end else if (timeout) begin
      mask_d  = '0;
      acc_d   = 1'b0;
      stale_d = 1'b1;
      if (state_q == FILLING) state_d = EMPTY;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= EMPTY;
      in_q         <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      tcnt_q       <= '0;
      mask_q       <= '0;
      acc_q        <= 1'b0;
      shadow_q     <= '0;
      sdp_q        <= '0;
      data_out_q   <= '0;
      dp_out_q     <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_q         <= in_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      tcnt_q       <= tcnt_d;
      mask_q       <= mask_d;
      acc_q        <= acc_d;
      shadow_q     <= shadow_d;
      sdp_q        <= sdp_d;
      data_out_q   <= data_out_d;
      dp_out_q     <= dp_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      stale_q      <= stale_d;
    end
  end

  assign data_out   = data_out_q;
  assign dp_out     = dp_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus random scan traffic, checked
// every cycle against a run-length / slot-array model of the receiver.
module tb_seg_scan_decoder;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = '0;
  logic [7:0]  seg = '0;
  logic [23:0] data_out;
  logic [5:0]  dp_out;
  logic        data_valid, frame_err, stale;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(clk), .sys_rst(rst), .sel(sel), .seg(seg),
    .data_out(data_out), .dp_out(dp_out), .data_valid(data_valid),
    .frame_err(frame_err), .stale(stale)
  );

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: value run lengths, slot array, edges since last capture.
  logic [10:0] m_prev;
  int          m_run, m_edge, m_last;
  logic [3:0]  m_nib [6];
  logic        m_dpv [6];
  bit   [5:0]  m_mask;
  bit          m_acc, m_valid, m_ferr, m_stale;
  logic [23:0] m_data;
  logic [5:0]  m_dp;

  function automatic logic [6:0] pat_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; default: return 7'h10;
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input int d, input bit dp);
    return {~dp, pat_of(d)};
  endfunction

  task automatic model_reset();
    m_prev = '0; m_run = 1; m_edge = 0; m_last = 0;
    m_mask = '0; m_acc = 0; m_valid = 0; m_ferr = 0; m_stale = 0;
    m_data = '0; m_dp = '0;
    for (int k = 0; k < 6; k++) begin m_nib[k] = '0; m_dpv[k] = 1'b0; end
  endtask

  task automatic model_step(input logic [10:0] v);
    int  s, dig;
    m_edge++;
    m_valid = 0;
    if (v == m_prev) m_run++;
    else begin m_run = 1; m_prev = v; end
    s = int'(v[10:8]);
    if (m_run == SETTLE + 1 && s <= 5) begin
      dig = -1;
      for (int d = 0; d < 10; d++) if (pat_of(d) == v[6:0]) dig = d;
      m_nib[s] = (dig < 0) ? 4'hF : 4'(dig);
      m_dpv[s] = ~v[7];
      m_acc    = m_acc | (dig < 0);
      m_mask[s] = 1'b1;
      m_last   = m_edge;
      if (m_mask == 6'h3F) begin
        for (int k = 0; k < 6; k++) begin
          m_data[4*k +: 4] = m_nib[k];
          m_dp[k]          = m_dpv[k];
        end
        m_ferr = m_acc; m_valid = 1; m_stale = 0; m_mask = '0; m_acc = 0;
      end
    end else if (m_edge - m_last >= TIMEOUT) begin
      m_mask = '0; m_acc = 0; m_stale = 1;
    end
  endtask

  task automatic compare();
    if (data_valid) dut_pulses++;
    check("valid", 32'(data_valid), 32'(m_valid));
    check("data",  32'(data_out),   32'(m_data));
    check("dp",    32'(dp_out),     32'(m_dp));
    check("ferr",  32'(frame_err),  32'(m_ferr));
    check("stale", 32'(stale),      32'(m_stale));
  endtask

  task automatic cycle(input logic [2:0] s, input logic [7:0] g);
    sel = s; seg = g;
    @(posedge clk);
    model_step({s, g});
    #1 compare();
  endtask

  task automatic hold(input logic [2:0] s, input logic [7:0] g, input int n);
    repeat (n) cycle(s, g);
  endtask

  // Reference scan: sel k shows digit 6-k, so the frame reads 123456.
  task automatic scan_ref(input int first, input int last);
    for (int k = first; k <= last; k++) hold(3'(k), seg_of(6 - k, k == 2), 10);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    compare();
    check("rst_data", 32'(data_out), 32'h0);
    @(posedge clk);
    #1 compare();
    #2 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 compare();
    #22 rst = 1'b0;

    // Clean scans: one pulse each.
    scan_ref(0, 5);
    check("clean_data", 32'(data_out), 32'h123456);
    check("clean_dp",   32'(dp_out),   32'h04);
    check("clean_ferr", 32'(frame_err), 32'h0);
    scan_ref(0, 5);
    check("pulses", 32'(dut_pulses), 32'd2);

    // Glitch on sel=3 before it settles.
    scan_ref(0, 2);
    hold(3'd3, seg_of(3, 0), 4);
    hold(3'd3, seg_of(8, 0), 3);
    scan_ref(3, 5);
    check("glitch_data", 32'(data_out), 32'h123456);
    check("glitch_ferr", 32'(frame_err), 32'h0);

    // Undecodable pattern on sel=1.
    scan_ref(0, 0);
    hold(3'd1, 8'hFF, 10);
    scan_ref(2, 5);
    check("bad_nib",  32'(data_out[7:4]), 32'hF);
    check("bad_ferr", 32'(frame_err), 32'h1);
    scan_ref(0, 5);
    check("bad_clear", 32'(frame_err), 32'h0);

    // Illegal sel dwell mid-frame.
    scan_ref(0, 2);
    hold(3'd7, 8'h5A, 20);
    scan_ref(3, 5);
    check("illegal_data", 32'(data_out), 32'h123456);

    // Dead bus after three captures.
    scan_ref(0, 2);
    hold(3'd2, seg_of(4, 1), 110);
    check("tmo_stale", 32'(stale), 32'h1);
    check("tmo_data",  32'(data_out), 32'h123456);
    scan_ref(0, 5);
    check("tmo_clear", 32'(stale), 32'h0);

    // Reset after four captures, then a full rescan.
    scan_ref(0, 3);
    do_reset();
    scan_ref(4, 5);
    check("rst_novalid", 32'(data_out), 32'h0);
    scan_ref(0, 5);
    check("rst_rescan", 32'(data_out), 32'h123456);

    // Random traffic.
    repeat (150) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) begin
        for (int k = 0; k < 6; k++) begin
          logic [7:0] g;
          g = seg_of($urandom_range(0, 9), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 9) == 0) g = 8'($urandom);
          if ($urandom_range(0, 4) == 0) hold(3'(k), 8'($urandom), $urandom_range(1, 6));
          hold(3'(k), g, $urandom_range(3, 9));
        end
      end else if (r < 75) begin
        hold(3'($urandom_range(6, 7)), 8'($urandom), $urandom_range(1, 25));
      end else if (r < 85) begin
        hold(3'($urandom_range(0, 5)), seg_of($urandom_range(0, 9), 1'($urandom_range(0, 1))),
             $urandom_range(1, 10));
      end else if (r < 93) begin
        hold(sel, seg, $urandom_range(80, 120));
      end else begin
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
